ed_sobel_window: RTL

Sobel edge-detection stage downstream of the two 320-entry edge-detection line buffers. It takes the current 12-bit RGB444 pixel plus the two line-buffer taps (one and two rows above), and builds a 3×3 grayscale window. It computes |Gx|+|Gy|, thresholds it, and emits one 12-bit output pixel per accepted input pixel to the display/steering path.

---
 rtl/ed_sobel_window_if.sv | 22 ++
 rtl/ed_sobel_window.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ed_sobel_window_if.sv
// Pixel-stream bundle between the line-buffer front end and the Sobel stage.
// master drives pixels and taps; slave (the filter) drives the filtered result.
interface ed_sobel_window_if;
  logic        sof;
  logic        pix_valid;
  logic [11:0] data_in;
  logic [11:0] tap_row1;
  logic [11:0] tap_row2;
  logic        out_valid;
  logic [11:0] out;
  logic        frame_done;

  modport master (
    output sof, pix_valid, data_in, tap_row1, tap_row2,
    input  out_valid, out, frame_done
  );

  modport slave (
    input  sof, pix_valid, data_in, tap_row1, tap_row2,
    output out_valid, out, frame_done
  );
endinterface

// File: rtl/ed_sobel_window.sv
// 3x3 Sobel edge stage on RGB444: gray window, |Gx|+|Gy|, threshold, 3-stage pipeline.
// Optional macro ED_SOBEL_MAG_OUT_EN drives a gray magnitude instead of the binary edge map.
module ed_sobel_window #(
  parameter int unsigned H_SIZE = 320,
  parameter int unsigned V_SIZE = 240,
  parameter logic [8:0]  THRESH = 9'd96
) (
  input logic              clk,
  input logic              rst_n,
  ed_sobel_window_if.slave bus
);

  localparam int unsigned    XW     = $clog2(H_SIZE);
  localparam int unsigned    YW     = $clog2(V_SIZE);
  localparam logic [XW-1:0]  X_LAST = XW'(H_SIZE - 1);
  localparam logic [YW-1:0]  Y_LAST = YW'(V_SIZE - 1);

  function automatic logic [5:0] gray(input logic [11:0] p);
    return {2'b00, p[11:8]} + {2'b00, p[7:4]} + {2'b00, p[3:0]};
  endfunction

  function automatic logic [8:0] wsum(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  function automatic logic [8:0] abs9(input logic signed [8:0] v);
    if (v[8]) begin
      return $unsigned(-v);
    end else begin
      return $unsigned(v);
    end
  endfunction

  logic [XW-1:0]          x_q, x_d, x_cur_s;
  logic [YW-1:0]          y_q, y_d, y_cur_s;
  logic [2:0][2:0][5:0]   win_q, win_d;
  logic                   full_s, last_s;
  logic                   v0_q, full0_q, last0_q;
  logic signed [8:0]      gx_q, gy_q, gx_d, gy_d;
  logic                   v1_q, full1_q, last1_q;
  logic [8:0]             mag_s;
  logic                   edge_s;
  logic [11:0]            pix_s, out_d;
  logic [11:0]            out_q;
  logic                   out_valid_q, frame_done_q;

  // sof re-tags the pixel on the same cycle as (0,0) before the counters advance
  always_comb begin
    x_cur_s = x_q;
    y_cur_s = y_q;
    if (bus.sof) begin
      x_cur_s = {XW{1'b0}};
      y_cur_s = {YW{1'b0}};
    end else begin
      x_cur_s = x_q;
      y_cur_s = y_q;
    end
    full_s = (x_cur_s >= XW'(2)) && (y_cur_s >= YW'(2));
    last_s = (x_cur_s == X_LAST) && (y_cur_s == Y_LAST);
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.pix_valid) begin
      if (x_cur_s == X_LAST) begin
        x_d = {XW{1'b0}};
        y_d = (y_cur_s == Y_LAST) ? {YW{1'b0}} : y_cur_s + YW'(1);
      end else begin
        x_d = x_cur_s + XW'(1);
        y_d = y_cur_s;
      end
    end else if (bus.sof) begin
      x_d = {XW{1'b0}};
      y_d = {YW{1'b0}};
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // row 0 is the oldest line (tap_row2); column 2 receives the newest pixel column
  always_comb begin
    win_d = win_q;
    if (bus.pix_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = gray(bus.tap_row2);
      win_d[1][2] = gray(bus.tap_row1);
      win_d[2][2] = gray(bus.data_in);
    end else begin
      win_d = win_q;
    end
  end

  always_comb begin
    gx_d = $signed(wsum(win_q[0][2], win_q[1][2], win_q[2][2])
                 - wsum(win_q[0][0], win_q[1][0], win_q[2][0]));
    gy_d = $signed(wsum(win_q[2][0], win_q[2][1], win_q[2][2])
                 - wsum(win_q[0][0], win_q[0][1], win_q[0][2]));
  end

  always_comb begin
    mag_s  = abs9(gx_q) + abs9(gy_q);
    edge_s = (mag_s > THRESH);
`ifdef ED_SOBEL_MAG_OUT_EN
    pix_s  = {mag_s[8:5], mag_s[8:5], mag_s[8:5]};
`else
    pix_s  = edge_s ? 12'hFFF : 12'h000;
`endif
    out_d  = full1_q ? pix_s : 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= {XW{1'b0}};
      y_q     <= {YW{1'b0}};
      win_q   <= '0;
      v0_q    <= 1'b0;
      full0_q <= 1'b0;
      last0_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      v0_q    <= bus.pix_valid;
      full0_q <= bus.pix_valid & full_s;
      last0_q <= bus.pix_valid & last_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q    <= 9'sd0;
      gy_q    <= 9'sd0;
      v1_q    <= 1'b0;
      full1_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      v1_q    <= v0_q;
      full1_q <= full0_q;
      last1_q <= last0_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= 12'h000;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= v1_q;
      frame_done_q <= v1_q & last1_q;
      if (v1_q) begin
        out_q <= out_d;
      end else begin
        out_q <= out_q;
      end
    end
  end

  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule
